// File: rtl/pc_unit_ras.sv
// Program-counter unit: prioritised next-PC selection (stall/branch/jump/return/sequential)
// with a circular return-address stack that feeds JR targets back from prior JALs.
module pc_unit_ras #(
    parameter int unsigned     PC_W      = 32,
    parameter int unsigned     IMM_W     = 16,
    parameter int unsigned     JADDR_W   = 26,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               branch,
    input  logic               branch_ne,
    input  logic               zflag,
    input  logic               jump,
    input  logic               link,
    input  logic               ret,
    input  logic [PC_W-1:0]    jr_target,
    input  logic [IMM_W-1:0]   baddr,
    input  logic [JADDR_W-1:0] jaddr,
    output logic [PC_W-1:0]    pc_out,
    output logic [PC_W-1:0]    pc_next,
    output logic [PC_W-1:0]    link_addr,
    output logic               ras_empty,
    output logic               ras_ovf,
    output logic               ras_unf
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 2) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int unsigned HI_W  = PC_W - JADDR_W - 2;

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_top;
    logic [CNT_W-1:0] ras_cnt;

    logic             br_taken;
    logic             ras_full;
    logic             do_push;
    logic             do_pop;
    logic             ovf_c;
    logic             unf_c;
    logic [PC_W-1:0]  br_target;
    logic [PC_W-1:0]  j_target;
    logic [PTR_W-1:0] push_ptr;

    assign link_addr = pc_out + PC_W'(1);
    assign br_taken  = branch & (branch_ne ? ~zflag : zflag);
    assign br_target = pc_out + {{(PC_W-IMM_W){baddr[IMM_W-1]}}, baddr};
    assign j_target  = {pc_out[PC_W-1 -: HI_W], {2{jaddr[JADDR_W-1]}}, jaddr};
    assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
    assign ras_empty = (ras_cnt == '0);
    // top always names the newest entry; a push lands one slot above it, which is
    // also the oldest slot once the stack is full
    assign push_ptr  = ras_top + PTR_W'(1);

    // Next-PC source selection, highest priority first
    always_comb begin
        pc_next = link_addr;
        do_push = 1'b0;
        do_pop  = 1'b0;
        ovf_c   = 1'b0;
        unf_c   = 1'b0;
        if (stall) begin
            pc_next = pc_out;
        end else if (br_taken) begin
            pc_next = br_target;
        end else if (jump) begin
            pc_next = j_target;
            do_push = link;
            ovf_c   = link & ras_full;
        end else if (ret) begin
            if (!ras_empty) begin
                pc_next = ras_mem[ras_top];
                do_pop  = 1'b1;
            end else begin
                pc_next = jr_target;
                unf_c   = 1'b1;
            end
        end
    end

    // PC, stack pointers and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out  <= RESET_PC;
            ras_top <= '0;
            ras_cnt <= '0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            pc_out  <= pc_next;
            ras_ovf <= ovf_c;
            ras_unf <= unf_c;
            if (do_push) begin
                ras_top <= push_ptr;
                if (!ras_full) begin
                    ras_cnt <= ras_cnt + CNT_W'(1);
                end
            end else if (do_pop) begin
                ras_top <= ras_top - PTR_W'(1);
                ras_cnt <= ras_cnt - CNT_W'(1);
            end
        end
    end

    // Stack storage needs no reset; validity is tracked by ras_cnt
    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_mem[push_ptr] <= link_addr;
        end
    end

endmodule
